alu_seq_ctrl: RTL and testbench

Command sequencer in front of the 4-bit ALU core. Accepts ALU commands (opcode, operands, chain flag) over a valid/ready interface and buffers them in a small FIFO. Issues one command at a time to the combinational ALU, samples the 8-bit result after a fixed latency, and returns it over a valid/ready response interface. Chain mode replaces operand A with the low nibble of the previous result, so multi-step computations run without host round-trips.

---
 rtl/alu_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: command sequencer in front of a combinational 4-bit ALU.
// Commands are queued in a small FIFO and issued one at a time.
// The ALU result is sampled after ALU_LAT cycles and returned over a
// valid/ready response port. Chained commands take operand A from the
// low nibble of the previous result.
module alu_seq_ctrl #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic       cmd_chain,
    output logic [3:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [7:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic [7:0] op_count
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = 13;
    localparam int WCNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // Each FIFO entry is packed as {chain, op, a, b}
    logic [ENT_W-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    state_t            state_reg;
    logic [WCNT_W-1:0] wait_cnt_reg;
    logic [3:0]        acc_reg;
    logic [3:0]        alu_op_reg;
    logic [3:0]        alu_a_reg;
    logic [3:0]        alu_b_reg;
    logic              rsp_valid_reg;
    logic [7:0]        rsp_data_reg;
    logic [7:0]        op_count_reg;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;

    // A full FIFO refuses a command even if the head is popped this cycle
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign cmd_ready = ena && !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = ena && (state_reg == S_ISSUE);
    assign head      = fifo_mem[rd_ptr_reg];

    assign alu_op    = alu_op_reg;
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign op_count  = op_count_reg;
    assign busy      = (state_reg != S_IDLE) || !empty;

    // Command storage; contents need no reset because the count gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {cmd_chain, cmd_op, cmd_a, cmd_b};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (ena) begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Sequencer FSM: issue head command, wait ALU_LAT cycles, hold result until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            wait_cnt_reg  <= '0;
            acc_reg       <= '0;
            alu_op_reg    <= '0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            op_count_reg  <= '0;
        end else if (ena) begin
            case (state_reg)
                S_IDLE: begin
                    if (!empty) begin
                        state_reg <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    alu_op_reg   <= head[11:8];
                    alu_a_reg    <= head[12] ? acc_reg : head[7:4];
                    alu_b_reg    <= head[3:0];
                    wait_cnt_reg <= WCNT_W'(ALU_LAT - 1);
                    state_reg    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_reg == '0) begin
                        rsp_data_reg  <= alu_result;
                        acc_reg       <= alu_result[3:0];
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= S_RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        op_count_reg  <= op_count_reg + 1'b1;
                        state_reg     <= empty ? S_IDLE : S_ISSUE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl: stub ALU, randomized commands, queue-based
// scoreboard filled at command acceptance and drained by a response monitor.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       ena;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       cmd_chain;
    logic [3:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       busy;
    logic [7:0] op_count;

    logic       c3_valid;
    logic       c3_ready;
    logic [3:0] c3_op;
    logic [3:0] c3_a;
    logic [3:0] c3_b;
    logic [3:0] alu_op3;
    logic [3:0] alu_a3;
    logic [3:0] alu_b3;
    logic [7:0] alu_result3;
    logic       rsp_valid3;
    logic       rsp_ready3;
    logic [7:0] rsp_data3;
    logic       busy3;
    logic [7:0] op_count3;

    logic       rand_en;
    logic       rnd_bit = 1'b0;
    logic       ready_dir;
    assign rsp_ready = rand_en ? rnd_bit : ready_dir;

    // Stub ALU: 0 = add, 1 = subtract mod 256, 2 = multiply
    function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'd0:    return 8'(a) + 8'(b);
            4'd1:    return 8'(a) - 8'(b);
            4'd2:    return 8'(a) * 8'(b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result  = alu_ref(alu_op, alu_a, alu_b);
    assign alu_result3 = alu_ref(alu_op3, alu_a3, alu_b3);

    alu_seq_ctrl #(.DEPTH(4), .ALU_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .op_count(op_count)
    );

    alu_seq_ctrl #(.DEPTH(4), .ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cmd_valid(c3_valid), .cmd_ready(c3_ready),
        .cmd_op(c3_op), .cmd_a(c3_a), .cmd_b(c3_b), .cmd_chain(1'b0),
        .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_result(alu_result3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
        .busy(busy3), .op_count(op_count3)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [3:0] model_acc;
    int         model_cnt;
    logic [3:0] last_op;
    logic [3:0] last_eff_a;
    logic [3:0] last_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // Response monitor: every handshake must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && ena && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rsp: got 0x%0h while no response was expected", rsp_data);
            end else begin
                chk("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
                chk("op_count_at_rsp", 32'(op_count), 32'(model_cnt & 255));
                model_cnt++;
            end
        end
    end

    // Present one command; called and returns at posedge+1
    task automatic send_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic ch);
        bit         done = 1'b0;
        logic [3:0] eff;
        logic [7:0] res;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch; cmd_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                eff = ch ? model_acc : a;
                res = alu_ref(op, eff, b);
                model_acc = res[3:0];
                exp_q.push_back(res);
                last_op = op; last_eff_a = eff; last_b = b;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", 32'(done), 32'd1);
    endtask

    task automatic send_rand();
        send_cmd(4'($urandom_range(0, 2)), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_chain = 1'b0;
        ready_dir = 1'b0; rand_en = 1'b0; model_acc = '0; model_cnt = 0;
        last_op = '0; last_eff_a = '0; last_b = '0;
        c3_valid = 1'b0; c3_op = '0; c3_a = '0; c3_b = '0; rsp_ready3 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Single op latency: valid rises on the third edge after acceptance
        send_cmd(4'd0, 4'd5, 4'd9, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lat_rsp_valid", 32'(rsp_valid), (k == 3) ? 32'd1 : 32'd0);
        end
        chk("single_rsp_data", 32'(rsp_data), 32'h0E);
        chk("single_busy", 32'(busy), 32'd1);
        @(posedge clk); #1; ready_dir = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_op_count", 32'(op_count), 32'd1);
        chk("single_busy_after", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Chain: 3+4 = 7, then 7*2 = 14
        send_cmd(4'd0, 4'd3, 4'd4, 1'b0);
        send_cmd(4'd2, 4'($urandom), 4'd2, 1'b1);
        drain();

        // Backpressure: one command issues, four fill the FIFO
        ready_dir = 1'b0;
        repeat (5) send_rand();
        repeat (4) begin
            @(negedge clk);
            chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk); #1; ready_dir = 1'b1;
        send_rand();
        drain();

        // Enable freeze during WAIT
        send_rand();
        @(posedge clk); #1;
        @(posedge clk); #1;
        ena = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("frz_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("frz_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("frz_alu_op", 32'(alu_op), 32'(last_op));
            chk("frz_alu_a", 32'(alu_a), 32'(last_eff_a));
            chk("frz_alu_b", 32'(alu_b), 32'(last_b));
        end
        @(posedge clk); #1; ena = 1'b1;
        drain();

        // Reset in WAIT with three commands still queued
        ready_dir = 1'b0;
        repeat (5) send_rand();
        repeat (5) @(posedge clk);
        #1; ready_dir = 1'b1;
        @(posedge clk); #1; ready_dir = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete(); model_acc = '0; model_cnt = 0;
        @(negedge clk);
        chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_op_count", 32'(op_count), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1; ready_dir = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        chk("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // 256 random ops with random backpressure; first chains from reset acc
        rand_en = 1'b1;
        send_cmd(4'($urandom_range(0, 2)), 4'($urandom), 4'($urandom), 1'b1);
        for (int n = 1; n < 256; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge clk); #1;
            end
            send_rand();
        end
        drain();
        rand_en = 1'b0;
        chk("op_count_wrap", 32'(op_count), 32'(model_cnt & 255));

        // ALU_LAT = 3 instance: 2 - 5 = 0xFD after three WAIT cycles
        c3_op = 4'd1; c3_a = 4'd2; c3_b = 4'd5; c3_valid = 1'b1;
        @(negedge clk);
        chk("lat3_cmd_ready", 32'(c3_ready), 32'd1);
        @(posedge clk); #1; c3_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                chk("lat3_alu_op", 32'(alu_op3), 32'd1);
                chk("lat3_alu_a", 32'(alu_a3), 32'd2);
                chk("lat3_alu_b", 32'(alu_b3), 32'd5);
            end
            chk("lat3_rsp_valid", 32'(rsp_valid3), (k == 5) ? 32'd1 : 32'd0);
        end
        chk("lat3_rsp_data", 32'(rsp_data3), 32'hFD);
        @(posedge clk); #1; rsp_ready3 = 1'b1;
        @(posedge clk); #1; rsp_ready3 = 1'b0;
        @(negedge clk);
        chk("lat3_op_count", 32'(op_count3), 32'd1);
        chk("lat3_busy", 32'(busy3), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
